quickselect_stage: RTL

- Parametrised quickselect partition stage for the streaming median filter.
- Consumes one control record (pivot, size, rank) and `size` pixels over first-word-fall-through (FWFT) FIFOs.
- Partitions pixels into lower and larger buffers and counts equals, then decides which partition holds the requested rank.
- Emits the next control record plus only the selected partition's pixels, read in place without a buffer copy.
- Stages chain through FIFOs. A stage that finds the median forwards it with `found=1`, and later stages pass it through.

---
 rtl/quickselect_stage.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/quickselect_stage.sv
// Quickselect partition stage for the streaming median filter.
// Reads one control record and its pixels, splits the pixels around the
// pivot into a lower and a larger buffer (counting equals), picks the
// partition that holds the requested rank and forwards it downstream.
// States:
//   IDLE     | waiting for a control record
//   FILL     | reading pixels, partitioning around the pivot
//   DECIDE   | choosing the partition that holds the rank
//   CTRL_OUT | writing the next control record downstream
//   SEND     | forwarding the selected pixels (or passing through)
module quickselect_stage #(
    parameter int DATA_W   = 8,
    parameter int MAX_SIZE = 1024,
    parameter int SIZE_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_ctrl_empty,
    output logic              in_ctrl_rd,
    input  logic [DATA_W-1:0] in_pivot,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [SIZE_W-1:0] in_pos,
    input  logic              in_found,
    input  logic [DATA_W-1:0] in_px,
    input  logic              in_px_empty,
    output logic              in_px_rd,
    output logic              out_ctrl_wr,
    input  logic              out_ctrl_full,
    output logic [DATA_W-1:0] out_pivot,
    output logic [SIZE_W-1:0] out_size,
    output logic [SIZE_W-1:0] out_pos,
    output logic              out_found,
    output logic [DATA_W-1:0] out_px,
    output logic              out_px_wr,
    input  logic              out_px_full,
    output logic              busy,
    output logic              err
);

    localparam int AW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam logic [SIZE_W-1:0] MAX_S = SIZE_W'(MAX_SIZE);

    typedef enum logic [2:0] {IDLE, FILL, DECIDE, CTRL_OUT, SEND} state_t;
    // Where SEND takes its pixels from.
    typedef enum logic [1:0] {SEL_LOW, SEL_LARG, SEL_PIV, SEL_PASS} sel_t;

    state_t state, next_state;
    sel_t   sel, dec_sel;

    logic [DATA_W-1:0] pivot_r;
    logic [SIZE_W-1:0] pos_r;
    logic              found_r;
    logic [SIZE_W-1:0] size_eff;
    logic [SIZE_W-1:0] lower_cnt, eq_cnt, larger_cnt;
    logic [SIZE_W-1:0] cnt;
    logic [DATA_W-1:0] min_lo, max_lo, min_hi, max_hi;

    logic [DATA_W-1:0] dec_pivot;
    logic [SIZE_W-1:0] dec_size, dec_pos;
    logic              dec_found;
    logic [SIZE_W:0]   lo_eq_sum;

    logic [DATA_W-1:0] lower_buf  [MAX_SIZE];
    logic [DATA_W-1:0] larger_buf [MAX_SIZE];

    assign busy = (state != IDLE);

    // Next state and FIFO strobes; strobes only fire when the FIFO allows.
    always_comb begin
        next_state  = state;
        in_ctrl_rd  = 1'b0;
        in_px_rd    = 1'b0;
        out_ctrl_wr = 1'b0;
        out_px_wr   = 1'b0;
        case (state)
            IDLE: begin
                in_ctrl_rd = !in_ctrl_empty;
                if (in_ctrl_rd)
                    next_state = (in_size == '0 || in_found) ? DECIDE : FILL;
            end
            FILL: begin
                in_px_rd = !in_px_empty;
                if (in_px_rd && cnt == size_eff - 1'b1)
                    next_state = DECIDE;
            end
            DECIDE: next_state = CTRL_OUT;
            CTRL_OUT: begin
                out_ctrl_wr = !out_ctrl_full;
                if (out_ctrl_wr)
                    next_state = (out_size == '0) ? IDLE : SEND;
            end
            SEND: begin
                if (sel == SEL_PASS) begin
                    out_px_wr = !in_px_empty && !out_px_full;
                    in_px_rd  = out_px_wr;
                end else begin
                    out_px_wr = !out_px_full;
                end
                if (out_px_wr && cnt == out_size - 1'b1)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pick the partition holding the rank and the next record's fields.
    always_comb begin
        lo_eq_sum = {1'b0, lower_cnt} + {1'b0, eq_cnt};
        dec_sel   = SEL_LOW;
        dec_found = 1'b0;
        dec_pivot = pivot_r;
        dec_size  = '0;
        dec_pos   = '0;
        if (found_r) begin
            dec_sel   = SEL_PASS;
            dec_found = 1'b1;
            dec_size  = size_eff;
            dec_pos   = pos_r;
        end else if (size_eff == '0) begin
            dec_sel = SEL_LOW;
        end else if (pos_r < lower_cnt) begin
            dec_sel   = SEL_LOW;
            dec_size  = lower_cnt;
            dec_pos   = pos_r;
            dec_pivot = DATA_W'(({1'b0, min_lo} + {1'b0, max_lo}) >> 1);
        end else if ({1'b0, pos_r} < lo_eq_sum) begin
            dec_sel   = SEL_PIV;
            dec_found = 1'b1;
            dec_size  = SIZE_W'(1);
        end else begin
            dec_sel   = SEL_LARG;
            dec_size  = larger_cnt;
            dec_pos   = pos_r - lower_cnt - eq_cnt;
            dec_pivot = DATA_W'(({1'b0, min_hi} + {1'b0, max_hi}) >> 1);
        end
    end

    // Forwarded pixel: read in place from the selected buffer.
    always_comb begin
        case (sel)
            SEL_LOW:  out_px = lower_buf[cnt[AW-1:0]];
            SEL_LARG: out_px = larger_buf[cnt[AW-1:0]];
            SEL_PIV:  out_px = out_pivot;
            default:  out_px = in_px;
        endcase
    end

    // Partition buffers; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (state == FILL && in_px_rd) begin
            if (in_px < pivot_r)
                lower_buf[lower_cnt[AW-1:0]] <= in_px;
            else if (in_px > pivot_r)
                larger_buf[larger_cnt[AW-1:0]] <= in_px;
        end
    end

    // State register, counters, trackers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= SEL_LOW;
            pivot_r    <= '0;
            pos_r      <= '0;
            found_r    <= 1'b0;
            size_eff   <= '0;
            lower_cnt  <= '0;
            eq_cnt     <= '0;
            larger_cnt <= '0;
            cnt        <= '0;
            min_lo     <= '0;
            max_lo     <= '0;
            min_hi     <= '0;
            max_hi     <= '0;
            out_pivot  <= '0;
            out_size   <= '0;
            out_pos    <= '0;
            out_found  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_ctrl_rd) begin
                        pivot_r    <= in_pivot;
                        pos_r      <= in_pos;
                        found_r    <= in_found;
                        size_eff   <= (in_size > MAX_S) ? MAX_S : in_size;
                        if (in_size > MAX_S)
                            err <= 1'b1;
                        lower_cnt  <= '0;
                        eq_cnt     <= '0;
                        larger_cnt <= '0;
                        cnt        <= '0;
                        // min starts high and max low so the first pixel sets both
                        min_lo     <= '1;
                        max_lo     <= '0;
                        min_hi     <= '1;
                        max_hi     <= '0;
                    end
                end
                FILL: begin
                    if (in_px_rd) begin
                        cnt <= cnt + 1'b1;
                        if (in_px < pivot_r) begin
                            lower_cnt <= lower_cnt + 1'b1;
                            if (in_px < min_lo) min_lo <= in_px;
                            if (in_px > max_lo) max_lo <= in_px;
                        end else if (in_px > pivot_r) begin
                            larger_cnt <= larger_cnt + 1'b1;
                            if (in_px < min_hi) min_hi <= in_px;
                            if (in_px > max_hi) max_hi <= in_px;
                        end else begin
                            eq_cnt <= eq_cnt + 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    out_pivot <= dec_pivot;
                    out_size  <= dec_size;
                    out_pos   <= dec_pos;
                    out_found <= dec_found;
                    sel       <= dec_sel;
                    cnt       <= '0;
                end
                SEND: begin
                    if (out_px_wr)
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
